platform_scroll_ctrl: RTL and testbench

//  Game-level sequencer for the jumper game. Owns the IDLE/PLAY/OVER state machine, the platform table
//  (NUM_PLAT entries of x,y) and the score. Each frame in PLAY it scrolls the world down when the ball

---
 rtl/platform_scroll_ctrl_if.sv | 17 +
 rtl/platform_scroll_ctrl.sv | 178 +++++++++++++++++
 tb/tb_platform_scroll_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/platform_scroll_ctrl_if.sv
// Signal bundle between the jumper-game sequencer and its keyboard, ball and platform neighbours.
interface platform_scroll_ctrl_if;
   logic [7:0]  keycode;
   logic [10:0] ball_y;
   logic [3:0]  plat_idx;
   logic [10:0] plat_x;
   logic [10:0] plat_y;
   logic [3:0]  scroll_amt;
   logic        ball_rst;
   logic [1:0]  game_state;
   logic [15:0] score;

   modport master (output keycode, ball_y, plat_idx,
                   input  plat_x, plat_y, scroll_amt, ball_rst, game_state, score);
   modport slave  (input  keycode, ball_y, plat_idx,
                   output plat_x, plat_y, scroll_amt, ball_rst, game_state, score);
endinterface

// File: rtl/platform_scroll_ctrl.sv
// Jumper-game sequencer: IDLE/PLAY/OVER control, platform table with scroll and respawn, and score.
module platform_scroll_ctrl #(
   parameter int         NUM_PLAT     = 8,
   parameter int         SCROLL_LINE  = 200,
   parameter int         MAX_SCROLL   = 4,
   parameter int         DEATH_Y      = 469,
   parameter logic [7:0] START_KEY    = 8'h2C,
   parameter int         PLAT_SPACING = 60
) (
   input logic                   frame_clk,
   input logic                   Reset,
   platform_scroll_ctrl_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_OVER = 2'd2} state_t;

   localparam logic [10:0] SCROLL_LINE_C = 11'(SCROLL_LINE);
   localparam logic [10:0] MAX_SCROLL_C  = 11'(MAX_SCROLL);
   localparam logic [10:0] DEATH_Y_C     = 11'(DEATH_Y);
   localparam logic [10:0] SPACING_C     = 11'(PLAT_SPACING);
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;

   state_t      state_r, state_nxt_s;
   logic [7:0]  key_q_r;
   logic [15:0] lfsr_r;
   logic [15:0] score_r, score_nxt_s;
   logic [3:0]  scroll_r, scroll_nxt_s;
   logic        ball_rst_r, ball_rst_nxt_s;
   logic [10:0] plat_x_r     [NUM_PLAT];
   logic [10:0] plat_y_r     [NUM_PLAT];
   logic [10:0] plat_x_nxt_s [NUM_PLAT];
   logic [10:0] plat_y_nxt_s [NUM_PLAT];
   logic [11:0] y_sum_s      [NUM_PLAT];
   logic [10:0] climb_s;
   logic [3:0]  d_s;
   logic        start_edge_s;
   logic [10:0] respawn_x_s;
   logic [10:0] rd_x_s, rd_y_s;

   function automatic logic [10:0] layout_y(input logic [4:0] idx);
      return 11'd470 - SPACING_C * {6'd0, idx};
   endfunction

   function automatic logic [10:0] layout_x(input logic [4:0] idx);
      logic [10:0] x;
      if (idx == 5'd0) x = 11'd240;
      else             x = 11'd40 + 11'd70 * {8'd0, idx[2:0]};
      return x;
   endfunction

   function automatic logic [15:0] sat16_add(input logic [15:0] a, input logic [3:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {13'd0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   // Fibonacci taps 16,14,13,11 in right-shift form; a non-zero seed never reaches zero.
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   assign start_edge_s = (bus.keycode == START_KEY) && (key_q_r != START_KEY);
   assign climb_s      = SCROLL_LINE_C - bus.ball_y;
   assign respawn_x_s  = {2'b00, lfsr_r[8:0]} + 11'd32;

   // Per-frame scroll distance and the pre-wrap platform heights it produces.
   always_comb begin
      d_s = 4'd0;
      if (bus.ball_y < SCROLL_LINE_C) begin
         if (climb_s > MAX_SCROLL_C) d_s = MAX_SCROLL_C[3:0];
         else                        d_s = climb_s[3:0];
      end else begin
         d_s = 4'd0;
      end
      for (int i = 0; i < NUM_PLAT; i++) begin
         y_sum_s[i] = {1'b0, plat_y_r[i]} + {8'd0, d_s};
      end
   end

   // Game FSM next state together with the table, score and output-register updates.
   always_comb begin
      state_nxt_s    = state_r;
      score_nxt_s    = score_r;
      scroll_nxt_s   = 4'd0;
      ball_rst_nxt_s = 1'b0;
      for (int i = 0; i < NUM_PLAT; i++) begin
         plat_x_nxt_s[i] = plat_x_r[i];
         plat_y_nxt_s[i] = plat_y_r[i];
      end
      case (state_r)
         ST_IDLE: begin
            for (int i = 0; i < NUM_PLAT; i++) begin
               plat_x_nxt_s[i] = layout_x(5'(i));
               plat_y_nxt_s[i] = layout_y(5'(i));
            end
            if (start_edge_s) begin
               state_nxt_s    = ST_PLAY;
               ball_rst_nxt_s = 1'b1;
               score_nxt_s    = 16'd0;
            end else begin
               state_nxt_s    = ST_IDLE;
            end
         end
         ST_PLAY: begin
            scroll_nxt_s = d_s;
            score_nxt_s  = sat16_add(score_r, d_s);
            for (int i = 0; i < NUM_PLAT; i++) begin
               if (y_sum_s[i] > 12'd479) begin
                  plat_y_nxt_s[i] = y_sum_s[i][10:0] - 11'd480;
                  plat_x_nxt_s[i] = respawn_x_s;
               end else begin
                  plat_y_nxt_s[i] = y_sum_s[i][10:0];
                  plat_x_nxt_s[i] = plat_x_r[i];
               end
            end
            if (bus.ball_y >= DEATH_Y_C) state_nxt_s = ST_OVER;
            else                         state_nxt_s = ST_PLAY;
         end
         ST_OVER: begin
            if (start_edge_s) begin
               state_nxt_s = ST_IDLE;
               for (int i = 0; i < NUM_PLAT; i++) begin
                  plat_x_nxt_s[i] = layout_x(5'(i));
                  plat_y_nxt_s[i] = layout_y(5'(i));
               end
            end else begin
               state_nxt_s = ST_OVER;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Frame-rate state register; Reset restores the power-up layout without waiting for a clock.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_r    <= ST_IDLE;
         key_q_r    <= 8'd0;
         lfsr_r     <= LFSR_SEED;
         score_r    <= 16'd0;
         scroll_r   <= 4'd0;
         ball_rst_r <= 1'b0;
         for (int i = 0; i < NUM_PLAT; i++) begin
            plat_x_r[i] <= layout_x(5'(i));
            plat_y_r[i] <= layout_y(5'(i));
         end
      end else begin
         state_r    <= state_nxt_s;
         key_q_r    <= bus.keycode;
         lfsr_r     <= lfsr_step(lfsr_r);
         score_r    <= score_nxt_s;
         scroll_r   <= scroll_nxt_s;
         ball_rst_r <= ball_rst_nxt_s;
         for (int i = 0; i < NUM_PLAT; i++) begin
            plat_x_r[i] <= plat_x_nxt_s[i];
            plat_y_r[i] <= plat_y_nxt_s[i];
         end
      end
   end

   // Table read port; out-of-range indices read as zero.
   always_comb begin
      rd_x_s = 11'd0;
      rd_y_s = 11'd0;
      for (int i = 0; i < NUM_PLAT; i++) begin
         rd_x_s = rd_x_s | (plat_x_r[i] & {11{bus.plat_idx == 4'(i)}});
         rd_y_s = rd_y_s | (plat_y_r[i] & {11{bus.plat_idx == 4'(i)}});
      end
   end

   assign bus.plat_x     = rd_x_s;
   assign bus.plat_y     = rd_y_s;
   assign bus.scroll_amt = scroll_r;
   assign bus.ball_rst   = ball_rst_r;
   assign bus.game_state = state_r;
   assign bus.score      = score_r;
endmodule

// File: tb/tb_platform_scroll_ctrl.sv
// Randomised frame-level bench for platform_scroll_ctrl against an integer game model.
module tb_platform_scroll_ctrl;
   localparam int NP = 8;

   logic frame_clk = 1'b0;
   logic Reset;
   platform_scroll_ctrl_if bus_if ();

   platform_scroll_ctrl #(.NUM_PLAT(NP)) dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus_if)
   );

   always #20 frame_clk = ~frame_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int m_state, m_score, m_scroll, m_ball_rst, m_lfsr, m_keyq;
   int m_x [NP];
   int m_y [NP];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected within %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic model_layout();
      for (int i = 0; i < NP; i++) begin
         m_y[i] = (470 - 60 * i) & 2047;
         m_x[i] = (i == 0) ? 240 : 40 + 70 * (i % 8);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_score = 0; m_scroll = 0; m_ball_rst = 0;
      m_lfsr = 'hACE1; m_keyq = 0;
      model_layout();
   endtask

   // One frame of game rules applied to the inputs seen at the clock edge.
   task automatic model_step(input int key, input int by);
      int  d;
      bit  se;
      se = (key == 'h2C) && (m_keyq != 'h2C);
      m_ball_rst = 0;
      m_scroll   = 0;
      if (m_state == 0) begin
         model_layout();
         if (se) begin m_state = 1; m_ball_rst = 1; m_score = 0; end
      end else if (m_state == 1) begin
         d = (by < 200) ? (((200 - by) < 4) ? (200 - by) : 4) : 0;
         m_scroll = d;
         for (int i = 0; i < NP; i++) begin
            m_y[i] += d;
            if (m_y[i] > 479) begin
               m_y[i] -= 480;
               m_x[i] = (m_lfsr % 512) + 32;
            end
         end
         m_score = (m_score + d > 65535) ? 65535 : m_score + d;
         if (by >= 469) m_state = 2;
      end else begin
         if (se) begin m_state = 0; model_layout(); end
      end
      m_keyq = key;
      m_lfsr = ((m_lfsr >> 1) | (((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15)) & 'hFFFF;
   endtask

   task automatic compare(input string tag);
      #1;
      check({tag, ".state"},    int'(bus_if.game_state), m_state);
      check({tag, ".score"},    int'(bus_if.score),      m_score);
      check({tag, ".scroll"},   int'(bus_if.scroll_amt), m_scroll);
      check({tag, ".ball_rst"}, int'(bus_if.ball_rst),   m_ball_rst);
      for (int i = 0; i < 16; i++) begin
         bus_if.plat_idx = 4'(i);
         #1;
         check($sformatf("%s.x%0d", tag, i), int'(bus_if.plat_x), (i < NP) ? m_x[i] : 0);
         check($sformatf("%s.y%0d", tag, i), int'(bus_if.plat_y), (i < NP) ? m_y[i] : 0);
      end
   endtask

   task automatic step(input int key, input int by);
      bus_if.keycode = 8'(key);
      bus_if.ball_y  = 11'(by);
      @(posedge frame_clk);
      model_step(key, by);
      compare("frame");
   endtask

   task automatic peek_entry(input int idx, output int x, output int y);
      bus_if.plat_idx = 4'(idx);
      #1;
      x = int'(bus_if.plat_x);
      y = int'(bus_if.plat_y);
   endtask

   function automatic int rand_key();
      case ($urandom_range(0, 2))
         0:       return 'h2C;
         1:       return 'h04;
         default: return 0;
      endcase
   endfunction

   initial begin
      int px, py, pulses, frozen;
      Reset = 1'b1;
      bus_if.keycode  = 8'd0;
      bus_if.ball_y   = 11'd300;
      bus_if.plat_idx = 4'd0;
      #10;
      model_reset();
      compare("reset");
      peek_entry(0, px, py);
      check("reset.lit_y0", py, 470);
      check("reset.lit_x0", px, 240);
      peek_entry(1, px, py);
      check("reset.lit_y1", py, 410);
      check("reset.lit_x1", px, 110);
      Reset = 1'b0;

      // Idle frames
      repeat (3) step(0, 300);
      check("t1.lit_state", int'(bus_if.game_state), 0);
      check("t1.lit_score", int'(bus_if.score), 0);

      // Held start key gives one start and one ball_rst pulse
      pulses = 0;
      repeat (5) begin
         step('h2C, 300);
         pulses += int'(bus_if.ball_rst);
      end
      check("t2.lit_pulses", pulses, 1);
      check("t2.lit_state", int'(bus_if.game_state), 1);

      step(0, 190);
      peek_entry(0, px, py);
      check("t3.lit_scroll4", int'(bus_if.scroll_amt), 4);
      check("t3.lit_y0_474", py, 474);
      check("t3.lit_score4", int'(bus_if.score), 4);
      step(0, 198);
      check("t3.lit_scroll2", int'(bus_if.scroll_amt), 2);
      check("t3.lit_score6", int'(bus_if.score), 6);
      step(0, 250);
      check("t3.lit_scroll0", int'(bus_if.scroll_amt), 0);

      step(0, 198);
      peek_entry(0, px, py);
      check("t4.lit_y0_478", py, 478);
      step(0, 100);
      peek_entry(0, px, py);
      check("t4.lit_y0_wrap", py, 2);
      check_range("t4.respawn_x", px, 32, 543);

      repeat (200) step(rand_key(), $urandom_range(120, 300));

      // Death with the start key held, then release and press
      step('h2C, 300);
      step('h2C, 469);
      check("t5.lit_over", int'(bus_if.game_state), 2);
      frozen = m_score;
      repeat (3) step('h2C, 100);
      check("t5.lit_still_over", int'(bus_if.game_state), 2);
      check("t5.score_frozen", int'(bus_if.score), frozen);
      step(0, 100);
      step('h2C, 100);
      check("t5.lit_idle", int'(bus_if.game_state), 0);
      peek_entry(0, px, py);
      check("t5.lit_y0", py, 470);
      peek_entry(7, px, py);
      check("t5.lit_y7", py, 50);

      repeat (400) step(rand_key(), $urandom_range(100, 479));

      // Force PLAY from any state, then reset asynchronously between edges
      step(0, 300); step('h2C, 300);
      step(0, 300); step('h2C, 300);
      check("t6.lit_play", int'(bus_if.game_state), 1);
      #2;
      Reset = 1'b1;
      model_reset();
      compare("async_rst");
      check("t6.lit_rst_state", int'(bus_if.game_state), 0);
      Reset = 1'b0;

      // Score saturation
      step(0, 300); step('h2C, 300);
      repeat (16383) step(0, 100);
      check("t6.lit_score_65532", int'(bus_if.score), 65532);
      step(0, 198);
      check("t6.lit_score_fffe", int'(bus_if.score), 'hFFFE);
      step(0, 100);
      check("t6.lit_score_ffff", int'(bus_if.score), 'hFFFF);
      step(0, 100);
      check("t6.lit_score_sat", int'(bus_if.score), 'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
